// File: rtl/ifmap_loader.sv
// ifmap_loader: loads one ifmap (width*width activation words) from a
// valid/ready stream into the activation buffer. It then pulses ctrl_start to
// the array system and waits for tpu_flag_done before reporting done.
// Optional build macro IFMAP_LOADER_TIMEOUT_EN adds a WAIT_DONE watchdog.
// The watchdog reports done+error after timeoutCycles cycles without
// completion.
module ifmap_loader #(
  parameter int dataSize      = 8,
  parameter int numRegister   = 256,
  parameter int timeoutCycles = 1024,
  localparam int addrWidth    = $clog2(numRegister)
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 cmd_start,
  input  logic [15:0]          cfg_ifmap_width,
  input  logic [addrWidth-1:0] cfg_base_addr,
  input  logic [dataSize-1:0]  s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [addrWidth-1:0] wr_addr,
  output logic [dataSize-1:0]  wr_data,
  output logic                 wr_en,
  output logic                 ctrl_start,
  input  logic                 tpu_flag_done,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT_DONE} state_t;

  localparam logic [addrWidth-1:0] LAST_ADDR = addrWidth'(numRegister - 1);

  state_t                state_q, state_d;
  logic [31:0]           words_q, words_d;     // N latched at command time
  logic [31:0]           idx_q, idx_d;         // beats accepted so far
  logic [addrWidth-1:0]  wptr_q, wptr_d;       // buffer address of next beat
  logic [addrWidth-1:0]  wr_addr_q, wr_addr_d;
  logic [dataSize-1:0]   wr_data_q, wr_data_d;
  logic                  wr_en_q, wr_en_d;
  logic                  ctrl_start_q, ctrl_start_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [31:0]           n_req_s;
`ifdef IFMAP_LOADER_TIMEOUT_EN
  logic [31:0]           tcnt_q, tcnt_d;       // cycles spent in WAIT_DONE
`endif

  // Full 32-bit word count so large widths are not truncated to a small N.
  assign n_req_s = 32'(cfg_ifmap_width) * 32'(cfg_ifmap_width);

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    words_d      = words_q;
    idx_d        = idx_q;
    wptr_d       = wptr_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_en_d      = 1'b0;
    ctrl_start_d = 1'b0;
    done_d       = 1'b0;
    error_d      = 1'b0;
`ifdef IFMAP_LOADER_TIMEOUT_EN
    tcnt_d       = tcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          if (n_req_s == 32'd0) begin
            done_d = 1'b1;
          end else if (n_req_s > 32'(numRegister)) begin
            done_d  = 1'b1;
            error_d = 1'b1;
          end else begin
            state_d = LOAD;
            words_d = n_req_s;
            idx_d   = 32'd0;
            wptr_d  = cfg_base_addr;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (s_valid) begin
          wr_en_d   = 1'b1;
          wr_data_d = s_data;
          wr_addr_d = wptr_q;
          wptr_d    = (wptr_q == LAST_ADDR) ? {addrWidth{1'b0}} : wptr_q + addrWidth'(1);
          idx_d     = idx_q + 32'd1;
          if (idx_q == words_q - 32'd1) begin
            // Last beat: the START cycle carries both ctrl_start and the final write.
            state_d      = START;
            ctrl_start_d = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      START: begin
        state_d = WAIT_DONE;
`ifdef IFMAP_LOADER_TIMEOUT_EN
        tcnt_d  = 32'd0;
`endif
      end
      WAIT_DONE: begin
        if (tpu_flag_done) begin
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef IFMAP_LOADER_TIMEOUT_EN
        end else if (tcnt_q == 32'(timeoutCycles - 1)) begin
          done_d  = 1'b1;
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d  = tcnt_q + 32'd1;
        end
`else
        end else begin
          state_d = WAIT_DONE;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any partial load.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      words_q      <= 32'd0;
      idx_q        <= 32'd0;
      wptr_q       <= {addrWidth{1'b0}};
      wr_addr_q    <= {addrWidth{1'b0}};
      wr_data_q    <= {dataSize{1'b0}};
      wr_en_q      <= 1'b0;
      ctrl_start_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef IFMAP_LOADER_TIMEOUT_EN
      tcnt_q       <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      words_q      <= words_d;
      idx_q        <= idx_d;
      wptr_q       <= wptr_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      ctrl_start_q <= ctrl_start_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef IFMAP_LOADER_TIMEOUT_EN
      tcnt_q       <= tcnt_d;
`endif
    end
  end

  assign s_ready    = (state_q == LOAD);
  assign busy       = (state_q != IDLE);
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_en      = wr_en_q;
  assign ctrl_start = ctrl_start_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_ifmap_loader.sv
// Scoreboard bench for ifmap_loader. Stimulus pushes expected writes,
// ctrl_start addresses and done/error outcomes into queues. A negedge monitor
// pops and compares them whenever the DUT presents wr_en, ctrl_start or done.
module tb_ifmap_loader;
  localparam int DW = 8;
  localparam int NR = 256;
  localparam int AW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          cmd_start = 1'b0;
  logic [15:0]   cfg_w = 16'd0;
  logic [AW-1:0] cfg_b = '0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en, ctrl_start, busy, done, error;
  logic          tpu_flag_done = 1'b0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           wq[$];   // expected buffer writes in order
  logic [AW-1:0] cq[$];   // expected wr_addr at each ctrl_start
  logic          sq[$];   // expected error value at each done pulse
  wr_t           mon_e;
  int            total = 0;
  int            bad = 0;

  ifmap_loader #(.dataSize(DW), .numRegister(NR), .timeoutCycles(TO)) dut (
    .clk(clk), .nrst(nrst), .cmd_start(cmd_start), .cfg_ifmap_width(cfg_w),
    .cfg_base_addr(cfg_b), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .ctrl_start(ctrl_start),
    .tpu_flag_done(tpu_flag_done), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {26'd0, s_ready, wr_en, ctrl_start, busy, done, error}, 32'd0);
    chk({nm, "_addr"}, 32'(wr_addr), 32'd0);
    chk({nm, "_data"}, 32'(wr_data), 32'd0);
  endtask

  // Monitor: compare every presented output event against the scoreboard.
  always @(negedge clk) begin
    if (nrst) begin
      if (wr_en) begin
        chk("write_expected", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
          mon_e = wq.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(mon_e.a));
          chk("wr_data", 32'(wr_data), 32'(mon_e.d));
        end
      end
      if (ctrl_start) begin
        chk("ctrl_start_with_wr_en", 32'(wr_en), 32'd1);
        chk("ctrl_start_expected", 32'(cq.size() != 0), 32'd1);
        if (cq.size() != 0) chk("ctrl_start_last_addr", 32'(wr_addr), 32'(cq.pop_front()));
      end
      if (done) begin
        chk("done_expected", 32'(sq.size() != 0), 32'd1);
        if (sq.size() != 0) chk("error_with_done", 32'(error), 32'(sq.pop_front()));
      end else if (error) begin
        chk("error_without_done", 32'(error), 32'd0);
      end
    end
  end

  // One command. dmode: 0 data k+1, 1 random. gmode: 0 back-to-back,
  // 1 valid pattern 1,0,0,1..., 2 random gaps. rst_at>0: reset after that many
  // beats. tmode: 0 short wait, 1 long wait (no watchdog), 2 watchdog expiry.
  task automatic job(input int w, input int b, input int dmode, input int gmode,
                     input int rst_at, input int tmode);
    int n, m, g, wt;
    n = w * w;
    cmd_start = 1'b1;
    cfg_w = 16'(w);
    cfg_b = AW'(b);
    if (n == 0) sq.push_back(1'b0);
    else if (n > NR) sq.push_back(1'b1);
    tick;
    cmd_start = 1'b0;
    cfg_w = 16'($urandom);
    cfg_b = AW'($urandom);
    if (n == 0 || n > NR) begin
      chk("reject_done", 32'(done), 32'd1);
      chk("reject_error", 32'(error), 32'(n > NR));
      chk("reject_idle", 32'(busy), 32'd0);
      tick;
      chk("reject_drained", 32'(sq.size() + wq.size()), 32'd0);
      return;
    end
    m = (rst_at > 0) ? rst_at : n;
    for (int k = 0; k < m; k++) begin
      g = (gmode == 0) ? 0 : (gmode == 1) ? ((k == 0) ? 0 : 2) : int'($urandom_range(0, 3));
      repeat (g) begin
        s_valid = 1'b0;
        s_data = DW'($urandom);
        cmd_start = ($urandom_range(0, 3) == 0);
        tick;
        cmd_start = 1'b0;
      end
      s_valid = 1'b1;
      s_data = (dmode == 0) ? DW'(k + 1) : DW'($urandom);
      chk("s_ready_load", 32'(s_ready), 32'd1);
      wq.push_back('{a: AW'((b + k) % NR), d: s_data});
      tick;
    end
    s_valid = 1'b0;
    if (rst_at > 0) begin
      @(negedge clk);
      #1;
      nrst = 1'b0;
      #1;
      chk_all_zero("reset_mid_load");
      @(negedge clk);
      nrst = 1'b1;
      tick;
      chk("after_reset_idle", 32'(busy), 32'd0);
      return;
    end
    cq.push_back(AW'((b + n - 1) % NR));
    sq.push_back(tmode == 2);
    chk("start_s_ready", 32'(s_ready), 32'd0);
    chk("start_ctrl", 32'(ctrl_start), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    tick;
    chk("wait_ctrl_low", 32'(ctrl_start), 32'd0);
    if (tmode == 2) begin
      repeat (TO - 1) begin
        tick;
        chk("watchdog_not_yet", 32'(done), 32'd0);
      end
      tick;
      chk("watchdog_done", 32'(done), 32'd1);
      chk("watchdog_error", 32'(error), 32'd1);
      chk("watchdog_idle", 32'(busy), 32'd0);
    end else begin
      wt = (tmode == 1) ? 40 : int'($urandom_range(0, 5));
      repeat (wt) begin
        chk("waiting_busy", {31'd0, busy & ~done}, 32'd1);
        tick;
      end
      tpu_flag_done = 1'b1;
      tick;
      tpu_flag_done = 1'b0;
      chk("done_after_flag", 32'(done), 32'd1);
      chk("idle_after_done", 32'(busy), 32'd0);
    end
    tick;
    chk("queues_drained", 32'(wq.size() + cq.size() + sq.size()), 32'd0);
  endtask

  initial begin
    #12;
    chk_all_zero("reset_state");
    @(negedge clk);
    nrst = 1'b1;
    tick;
    chk_all_zero("post_reset");
    tpu_flag_done = 1'b1;
    tick;
    tpu_flag_done = 1'b0;
    tick;
    chk("flag_ignored_in_idle", 32'(done | busy), 32'd0);

    job(3, 0, 0, 0, 0, 0);
    job(2, 254, 1, 0, 0, 0);
    job(3, int'($urandom_range(0, 255)), 1, 1, 0, 0);
    job(17, 10, 1, 0, 0, 0);
    job(0, 10, 1, 0, 0, 0);
    job(256, 3, 1, 0, 0, 0);
    job(3, 7, 0, 0, 4, 0);
    job(3, 7, 0, 0, 0, 0);
`ifdef IFMAP_LOADER_TIMEOUT_EN
    job(3, 5, 1, 0, 0, 2);
`else
    job(3, 5, 1, 0, 0, 1);
`endif
    job(16, int'($urandom_range(0, 255)), 1, 2, 0, 0);
    for (int j = 0; j < 6; j++) begin
      job(int'($urandom_range(0, 18)), int'($urandom_range(0, 255)), 1, 2, 0, 0);
    end
    tick;
    chk("final_drained", 32'(wq.size() + cq.size() + sq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
